// File: rtl/spi_param_regfile.sv
// -----------------------------------------------------------------------------
// spi_param_regfile
//
// Parametrised SPI register-file peripheral. A frame, selected by cs_n low,
// starts with an (ADDR_W+1)-bit command, MSB first. The command's top bit is
// rw (1 = read) and the remaining bits are the start address. The command is
// followed by any number of DATA_W-bit data words (burst).
//   - Writes land in NUM_REGS read/write registers at addresses
//     0..NUM_REGS-1.
//   - Reads return those registers, or NUM_RO read-only status words at
//     addresses NUM_REGS..NUM_REGS+NUM_RO-1.
//   - Any other address reads as 0, drops writes, and sets the sticky
//     addr_err flag.
//
// Build option:
//   SPI_PARAM_REGFILE_AUTOINC_EN
//     Defined:   the address pointer advances by one (mod 2^ADDR_W) after
//                every data word.
//     Undefined: the pointer stays on the command address for the whole
//                frame.
//
// Ports:
//   sclk        SPI clock, all state changes on its rising edge
//   rstn        asynchronous active-low reset
//   cs_n        frame select, active-low; going high aborts the frame at once
//   serial_in   controller-to-peripheral data, MSB first
//   serial_out  peripheral-to-controller data, registered, MSB first
//   ro_data     NUM_RO read-only words, word i at [i*DATA_W +: DATA_W]
//   reg_q       NUM_REGS register contents, same packing as ro_data
//   wr_strobe   one-hot pulse, one sclk cycle, per committed register write
//   addr_err    sticky unmapped-address / read-only-write flag
//   busy        high while the frame state machine is not idle
// -----------------------------------------------------------------------------
module spi_param_regfile #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7,
    parameter int NUM_REGS = 8,
    parameter int NUM_RO   = 2
) (
    input  logic                         sclk,
    input  logic                         rstn,
    input  logic                         cs_n,
    input  logic                         serial_in,
    output logic                         serial_out,
    input  logic [NUM_RO*DATA_W-1:0]     ro_data,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         addr_err,
    output logic                         busy
);

    localparam int CNT_MAX = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  CMD_LAST = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0]  WR_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  RD_LAST  = CNT_W'(DATA_W);
    localparam logic [ADDR_W:0]   RW_END   = (ADDR_W + 1)'(NUM_REGS);

    generate
        if (NUM_REGS + NUM_RO > (1 << ADDR_W)) begin : g_map_check
            $error("spi_param_regfile: NUM_REGS+NUM_RO exceeds the address space");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    bit_cnt_reg;
    logic [ADDR_W-1:0]   cmd_sh_reg;     // command bits received so far
    logic [DATA_W-2:0]   data_sh_reg;    // write-data bits received so far
    logic [DATA_W-1:0]   out_sh_reg;     // read bits still to be shifted out
    logic [ADDR_W-1:0]   ptr_reg;        // address of the next data word

    // Unpacked views of the packed word buses for the read multiplexer.
    logic [DATA_W-1:0] ro_word [NUM_RO];
    logic [DATA_W-1:0] rw_word [NUM_REGS];

    generate
        for (genvar gi = 0; gi < NUM_RO; gi++) begin : g_ro_unpack
            assign ro_word[gi] = ro_data[gi*DATA_W +: DATA_W];
        end
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rw_unpack
            assign rw_word[gi] = reg_q[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Decode of what the current edge will do.
    logic [ADDR_W:0]     cmd_next;
    logic [DATA_W-1:0]   data_next;
    logic                cmd_last;
    logic                wr_last;
    logic                rd_reload;
    logic                rd_load;
    logic [ADDR_W-1:0]   load_addr;
    logic [ADDR_W-1:0]   ptr_after;
    logic [DATA_W-1:0]   load_word;
    logic                load_mapped;
    logic                wr_mapped;
    logic                err_event;
    logic [NUM_REGS-1:0] wr_en_next;

    assign cmd_next  = {cmd_sh_reg, serial_in};
    assign data_next = {data_sh_reg, serial_in};
    assign cmd_last  = (state_reg == CMD)   && (bit_cnt_reg == CMD_LAST);
    assign wr_last   = (state_reg == WDATA) && (bit_cnt_reg == WR_LAST);
    assign rd_reload = (state_reg == RDATA) && (bit_cnt_reg == RD_LAST);
    assign rd_load   = (cmd_last && cmd_next[ADDR_W]) || rd_reload;

    // A read word loads from the fresh command address on the command edge,
    // and from the pointer on every later word boundary.
    assign load_addr = cmd_last ? cmd_next[ADDR_W-1:0] : ptr_reg;

`ifdef SPI_PARAM_REGFILE_AUTOINC_EN
    assign ptr_after = load_addr + ADDR_W'(1);
`else
    assign ptr_after = load_addr;
`endif

    assign wr_mapped = ({1'b0, ptr_reg} < RW_END);
    assign err_event = (rd_load && !load_mapped) || (wr_last && !wr_mapped);

    always_comb begin
        load_word   = '0;
        load_mapped = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ({1'b0, load_addr} == (ADDR_W + 1)'(i)) begin
                load_word   = rw_word[i];
                load_mapped = 1'b1;
            end
        end
        for (int i = 0; i < NUM_RO; i++) begin
            if ({1'b0, load_addr} == (ADDR_W + 1)'(NUM_REGS + i)) begin
                load_word   = ro_word[i];
                load_mapped = 1'b1;
            end
        end
    end

    always_comb begin
        wr_en_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_en_next[i] = wr_last && (ptr_reg == ADDR_W'(i));
        end
    end

    // Register bank and error flag survive a frame abort, so only rstn clears
    // them. Sampling cs_n here means a commit on the same edge as cs_n rising
    // is discarded.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            reg_q    <= '0;
            addr_err <= 1'b0;
        end else if (!cs_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en_next[i]) begin
                    reg_q[i*DATA_W +: DATA_W] <= data_next;
                end
            end
            if (err_event) begin
                addr_err <= 1'b1;
            end
        end
    end

    // Frame state machine. Reset and abort clear exactly the same state.
    always_ff @(posedge sclk or negedge rstn or posedge cs_n) begin
        if (!rstn || cs_n) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            cmd_sh_reg  <= '0;
            data_sh_reg <= '0;
            out_sh_reg  <= '0;
            ptr_reg     <= '0;
            serial_out  <= 1'b0;
            wr_strobe   <= '0;
        end else begin
            wr_strobe <= '0;
            case (state_reg)
                IDLE: begin
                    // First edge of the frame already carries command bit 0.
                    cmd_sh_reg  <= cmd_next[ADDR_W-1:0];
                    bit_cnt_reg <= CNT_W'(1);
                    state_reg   <= CMD;
                end
                CMD: begin
                    cmd_sh_reg <= cmd_next[ADDR_W-1:0];
                    if (cmd_last) begin
                        if (cmd_next[ADDR_W]) begin
                            state_reg   <= RDATA;
                            bit_cnt_reg <= CNT_W'(1);
                            ptr_reg     <= ptr_after;
                            serial_out  <= load_word[DATA_W-1];
                            out_sh_reg  <= {load_word[DATA_W-2:0], 1'b0};
                        end else begin
                            state_reg   <= WDATA;
                            bit_cnt_reg <= '0;
                            ptr_reg     <= cmd_next[ADDR_W-1:0];
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    end
                end
                WDATA: begin
                    if (wr_last) begin
                        bit_cnt_reg <= '0;
                        data_sh_reg <= '0;
                        wr_strobe   <= wr_en_next;
                        ptr_reg     <= ptr_after;
                    end else begin
                        data_sh_reg <= data_next[DATA_W-2:0];
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    end
                end
                RDATA: begin
                    // Word boundaries follow back to back: the reload edge
                    // presents the next word's MSB with no idle bit between.
                    if (rd_reload) begin
                        bit_cnt_reg <= CNT_W'(1);
                        ptr_reg     <= ptr_after;
                        serial_out  <= load_word[DATA_W-1];
                        out_sh_reg  <= {load_word[DATA_W-2:0], 1'b0};
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        serial_out  <= out_sh_reg[DATA_W-1];
                        out_sh_reg  <= {out_sh_reg[DATA_W-2:0], 1'b0};
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: doc/spi_param_regfile.md
Name: spi_param_regfile

Overview:
- Parametrised SPI register-file peripheral. It is the successor to the fixed 8-bit SPI write/readout path with its hard-wired register addresses.
- Deserialises command + data frames on sclk into a bank of NUM_REGS read/write registers.
- Serves reads of both those registers and NUM_RO read-only status words, for example PLL lock.
- Adds framing by cs_n, multi-word burst access and address-error reporting, none of which the previous fixed-address block had.

Parameters:
- DATA_W, 8: bits per data word.
- ADDR_W, 7: address bits in the command. Command length is ADDR_W+1 bits.
- NUM_REGS, 8: read/write registers, at addresses 0..NUM_REGS-1.
- NUM_RO, 2: read-only words, at addresses NUM_REGS..NUM_REGS+NUM_RO-1. NUM_REGS+NUM_RO must not exceed 2^ADDR_W; elaboration fails otherwise.

Ports:
- sclk, input, 1: SPI clock. All state changes on posedge.
- rstn, input, 1: reset, asynchronous, active-low.
- cs_n, input, 1: frame select, active-low. High acts as an asynchronous frame abort.
- serial_in, input, 1: controller-to-peripheral data, MSB first.
- serial_out, output, 1: peripheral-to-controller data, registered, MSB first.
- ro_data, input, NUM_RO*DATA_W: read-only words. Word i is in bits [i*DATA_W +: DATA_W].
- reg_q, output, NUM_REGS*DATA_W: register contents, same packing as ro_data.
- wr_strobe, output, NUM_REGS: one-hot, one-sclk pulse per committed write.
- addr_err, output, 1: sticky; set on any access to an unmapped address or a write to a read-only address.
- busy, output, 1: high while the FSM is not in IDLE.

Behaviour:
- Reset (rstn low, async): reg_q=0, wr_strobe=0, addr_err=0, serial_out=0, busy=0, FSM=IDLE, all counters and shift registers 0.
- Frame abort (cs_n high, async): FSM=IDLE, bit counter=0, shift registers=0, serial_out=0, wr_strobe=0.
  - A partially received word is discarded.
  - reg_q and addr_err are retained.
- FSM states: IDLE, CMD, WDATA, RDATA.
- IDLE -> CMD: on the first posedge with cs_n low. That edge captures command bit 0.
- CMD: shifts serial_in in for ADDR_W+1 edges.
  - Bit ADDR_W of the command is rw (1=read). Bits [ADDR_W-1:0] are the address.
  - The edge capturing the last command bit loads the address pointer and moves to WDATA or RDATA.
- WDATA: shifts DATA_W bits. The edge capturing the last bit commits the word.
  - Address < NUM_REGS: reg_q word updates on that same edge, and wr_strobe[addr] is high for exactly the following sclk cycle.
  - Any other address: the write is dropped, no strobe fires, and addr_err is set.
  - Bit counter clears; the FSM stays in WDATA for the next burst word.
- RDATA:
  - On the edge that completes the command, and every DATA_W edges thereafter, the output shifter loads the word at the pointer and serial_out takes that word's MSB.
  - Each following edge shifts out the next bit, so there are DATA_W bits per word with no gap between words.
  - Unmapped address: the word reads as 0 and addr_err is set.
  - serial_in is ignored.
- Data read is sampled at its load edge. Later changes to ro_data do not alter a word already being shifted.
- Address pointer: ADDR_W bits. It advances after each word and wraps from 2^ADDR_W-1 to 0 (see Optional Feature).
- Simultaneous events:
  - cs_n rising on the same edge as a commit: cs_n wins, and the word is not committed.
  - rstn dominates cs_n.
- wr_strobe is never asserted for two different registers in the same cycle.

Optional Feature:
- Macro: SPI_PARAM_REGFILE_AUTOINC_EN.
- Defined: the pointer increments by 1 (modulo 2^ADDR_W) after each committed or read word. Bursts therefore sweep consecutive addresses.
- Undefined: the pointer is constant for the whole frame.
  - Burst writes rewrite the same register, with one strobe per word.
  - Burst reads repeat the same address, re-sampled at each load edge.
- All other behaviour is identical in both builds.

Test Plan (DATA_W=8, ADDR_W=7, NUM_REGS=8, NUM_RO=2):
- Reset check: assert rstn low mid-frame -> all outputs 0 immediately. After release, reg_q=0 and addr_err=0.
- Single write: cs_n low, shift 0x03 then 0xA5 -> after edge 16, reg_q word3=0xA5; wr_strobe=8'h08 for exactly one cycle; busy=1 until cs_n high.
- Burst write with AUTOINC_EN: command 0x06, data 0x11, 0x22, 0x33 -> word6=0x11 and word7=0x22; 0x33 is dropped at address 8 (read-only) and addr_err=1; strobes are 8'h40 then 8'h80.
- Read of read-only word: ro_data word0=0x5A, command 0x88 -> serial_out after edges 8..15 = 0,1,0,1,1,0,1,0. A following word reads ro_data word1. Command 0xFF then reads 0 and sets addr_err.
- Abort: command 0x01, 4 data bits, then cs_n high -> word1 unchanged, no strobe, serial_out=0. The next full frame writing 0x3C to address 1 succeeds.
- Without the macro: command 0x02, data 0x01, 0x02 -> word2=0x02, two strobes of 8'h04, word3 untouched.
